writeback_buffer: RTL and testbench
===================================

// Module: writeback_buffer
// PURPOSE
//  Result writeback queue between the ALU/execute stage and the 8x8 register file
//  write port (WriteReg/WriteData, R0 hardwired to zero).
//  Buffers up to DEPTH (register, data) results and retires them in order, one per cycle.
//  Retirement is held off while the register file is busy (wr_stall).
//  Optional bypass lets operand fetch read results that are still pending.
// PARAMETERS
//  DEPTH   4  FIFO entries; power of 2, >=2
//  DATA_W  8  result width
//  ADDR_W  3  register index width
// PORTS
//  clk       in   1                     rising-edge clock
//  rst       in   1                     reset, asynchronous, active-high
//  in_valid  in   1                     producer has a result
//  in_ready  out  1                     buffer can accept (= !full)
//  in_reg    in   ADDR_W                destination register
//  in_data   in   DATA_W                result value
//  wr_stall  in   1                     register file busy; no pop this cycle
//  wr_en     out  1                     write strobe to register file (registered)
//  wr_reg    out  ADDR_W                write register index (registered)
//  wr_data   out  DATA_W                write data (registered)
//  count     out  $clog2(DEPTH+1)       entries held (excludes output reg)
//  empty     out  1                     count==0
//  full      out  1                     count==DEPTH
//  lk_reg1/2 in   ADDR_W                bypass lookup indices   [WB_BYPASS_EN]
//  lk_hit1/2 out  1                     pending result found    [WB_BYPASS_EN]
//  lk_dat1/2 out  DATA_W                pending result value    [WB_BYPASS_EN]
// BEHAVIOUR
//  - Reset: head=tail=0, count=0, wr_en=0, wr_reg=0, wr_data=0, empty=1, full=0,
//    in_ready=1, lk_hit*=0, lk_dat*=0. Reset mid-operation discards all entries.
//    No write is issued for discarded entries.
//  - Push: in_valid&&in_ready at posedge -> store at tail, tail++ mod DEPTH.
//    Exception: in_reg==0 completes the handshake but is dropped (no store, no write).
//  - Pop: at posedge, if count>0 && !wr_stall, load head into wr_reg/wr_data, set wr_en=1,
//    and head++. Otherwise wr_en=0 at that edge.
//    Each entry yields exactly one 1-cycle wr_en pulse.
//  - Latency: push at edge E0 into empty buffer -> popped at E1 -> regfile captures at E2.
//  - Push and pop on the same edge: count unchanged.
//    When full, in_ready=0 even if a pop occurs that cycle (no pass-through).
//  - Strict FIFO order. Multiple pending writes to the same register retire oldest-first.
//  - in_ready, empty, full decode from count; no combinational path from in_valid.
// CONFIGURATION
//  WB_BYPASS_EN defined:
//  - lk_hit/lk_dat are combinational.
//  - Lookup covers all valid FIFO entries plus the output register when wr_en=1.
//  - Newest match wins: FIFO newest .. oldest, then output register.
//  - lk_reg==0 never hits, and lk_dat=0.
//  - On a miss, lk_dat=0.
//  WB_BYPASS_EN undefined: lk_* ports absent; no lookup logic.
// TESTING
//  1 Reset: rst=1 mid-stream with 3 entries -> wr_en=0, count=0, in_ready=1.
//    No writes follow after rst falls.
//  2 Push (R3,8'h5A) to empty -> wr_en=1, wr_reg=3, wr_data=8'h5A one edge later, for 1 cycle.
//  3 Push R1..R4 (11,22,33,44) with wr_stall=1 -> full=1, in_ready=0.
//    Then release wr_stall -> 4 writes in order on consecutive cycles.
//  4 Push (R0,8'hFF) -> handshake accepted, count stays 0, no wr_en pulse.
//  5 Push 6 entries with wr_stall toggling each cycle -> order preserved.
//    Also check pointer wrap, with count tracking push-pop exactly.
//  6 [WB_BYPASS_EN] Stall, push (R2,10) then (R2,20) -> lk_reg1=2 gives hit=1, dat=20.
//    lk_reg2=0 -> hit=0. Unstall -> after (R2,10) retires, lookup still returns 20.

Source files
------------

// File: rtl/writeback_buffer.sv
// writeback_buffer: in-order result queue feeding the register-file write port.
// Defining WB_BYPASS_EN adds two combinational lookup ports over pending results.
module writeback_buffer #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ADDR_W-1:0]          in_reg,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       wr_stall,
   output logic                       wr_en,
   output logic [ADDR_W-1:0]          wr_reg,
   output logic [DATA_W-1:0]          wr_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full
`ifdef WB_BYPASS_EN
   ,
   input  logic [ADDR_W-1:0]          lk_reg1,
   input  logic [ADDR_W-1:0]          lk_reg2,
   output logic                       lk_hit1,
   output logic                       lk_hit2,
   output logic [DATA_W-1:0]          lk_dat1,
   output logic [DATA_W-1:0]          lk_dat2
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [ADDR_W-1:0] reg_mem  [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic              push;
   logic              store;
   logic              pop;

   // Status decodes only from registered count, so in_ready never depends on in_valid.
   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign in_ready = !full;

   // Writes to R0 complete the handshake but are discarded.
   assign push  = in_valid && in_ready;
   assign store = push && (in_reg != '0);
   assign pop   = !empty && !wr_stall;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         wr_en   <= 1'b0;
         wr_reg  <= '0;
         wr_data <= '0;
      end else begin
         if (store)
            tail <= tail + PTR_W'(1);
         if (pop) begin
            head    <= head + PTR_W'(1);
            wr_reg  <= reg_mem[head];
            wr_data <= data_mem[head];
         end
         wr_en <= pop;
         count <= count + CNT_W'(store) - CNT_W'(pop);
      end
   end

   // NOTE: storage is deliberately not reset; count alone decides which slots are valid.
   always_ff @(posedge clk) begin
      if (store) begin
         reg_mem[tail]  <= in_reg;
         data_mem[tail] <= in_data;
      end
   end

`ifdef WB_BYPASS_EN
   // Scan order gives priority: output register lowest, then FIFO oldest to newest.
   function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] key);
      logic             hit;
      logic [DATA_W-1:0] dat;
      logic [PTR_W-1:0] idx;
      // NOTE: every local gets a default before any conditional update, so no latch is inferred.
      hit = 1'b0;
      dat = '0;
      idx = '0;
      if (wr_en && (wr_reg == key)) begin
         hit = 1'b1;
         dat = wr_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PTR_W'(i);
         if ((CNT_W'(i) < count) && (reg_mem[idx] == key)) begin
            hit = 1'b1;
            dat = data_mem[idx];
         end
      end
      if (key == '0) begin
         hit = 1'b0;
         dat = '0;
      end
      return {hit, dat};
   endfunction

   always_comb begin
      {lk_hit1, lk_dat1} = lookup(lk_reg1);
      {lk_hit2, lk_dat2} = lookup(lk_reg2);
   end
`endif

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed self-checking bench for writeback_buffer; bypass checks run when WB_BYPASS_EN is defined.
module tb_writeback_buffer;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_reg;
   logic [7:0] in_data;
   logic       wr_stall;
   logic       wr_en;
   logic [2:0] wr_reg;
   logic [7:0] wr_data;
   logic [2:0] count;
   logic       empty;
   logic       full;
`ifdef WB_BYPASS_EN
   logic [2:0] lk_reg1, lk_reg2;
   logic       lk_hit1, lk_hit2;
   logic [7:0] lk_dat1, lk_dat2;
`endif

   int n_checks = 0;
   int n_fails  = 0;
   logic [10:0] wq[$];   // {reg, data} of every write pulse seen

   writeback_buffer #(.DEPTH(4), .DATA_W(8), .ADDR_W(3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_reg(in_reg), .in_data(in_data), .wr_stall(wr_stall),
      .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
      .count(count), .empty(empty), .full(full)
`ifdef WB_BYPASS_EN
      , .lk_reg1(lk_reg1), .lk_reg2(lk_reg2), .lk_hit1(lk_hit1), .lk_hit2(lk_hit2),
      .lk_dat1(lk_dat1), .lk_dat2(lk_dat2)
`endif
   );

   always #5 clk = ~clk;

   // wr_en is high for one full period, so one negedge sample per pulse.
   always @(negedge clk)
      if (wr_en) wq.push_back({wr_reg, wr_data});

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] r, input logic [7:0] d);
      in_valid = 1'b1;
      in_reg   = r;
      in_data  = d;
      step();
      in_valid = 1'b0;
   endtask

   logic [7:0] t3_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
   int         mcount;
   logic       mpop;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_reg = '0; in_data = '0; wr_stall = 1'b0;
`ifdef WB_BYPASS_EN
      lk_reg1 = '0; lk_reg2 = '0;
`endif
      step(); step();
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_reg", wr_reg, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_in_ready", in_ready, 1);
      rst = 1'b0;
      step();

      // 1: reset mid-stream discards held entries
      wr_stall = 1'b1;
      push(3'd1, 8'h01); push(3'd2, 8'h02); push(3'd3, 8'h03);
      check("t1_count_before", count, 3);
      rst = 1'b1;
      #1;
      check("t1_wr_en", wr_en, 0);
      check("t1_count", count, 0);
      check("t1_in_ready", in_ready, 1);
      step();
      rst = 1'b0;
      wr_stall = 1'b0;
      wq.delete();
      repeat (6) step();
      check("t1_no_writes", wq.size(), 0);

      // 2: single push, popped one edge later for one cycle
      push(3'd3, 8'h5A);
      check("t2_e0_wr_en", wr_en, 0);
      check("t2_e0_count", count, 1);
      step();
      check("t2_e1_wr_en", wr_en, 1);
      check("t2_e1_wr_reg", wr_reg, 3);
      check("t2_e1_wr_data", wr_data, 8'h5A);
      check("t2_e1_count", count, 0);
      step();
      check("t2_e2_wr_en", wr_en, 0);
      check("t2_pulses", wq.size(), 1);
      wq.delete();

      // 3: fill while stalled, then drain in order
      wr_stall = 1'b1;
      for (int i = 0; i < 4; i++) push(3'(i + 1), t3_data[i]);
      check("t3_full", full, 1);
      check("t3_in_ready", in_ready, 0);
      check("t3_count", count, 4);
      wr_stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("t3_wr_en_%0d", i), wr_en, 1);
         check($sformatf("t3_wr_reg_%0d", i), wr_reg, i + 1);
         check($sformatf("t3_wr_data_%0d", i), wr_data, t3_data[i]);
      end
      step();
      check("t3_idle_wr_en", wr_en, 0);
      check("t3_empty", empty, 1);
      wq.delete();

      // 4: R0 push is accepted but dropped
      check("t4_in_ready", in_ready, 1);
      push(3'd0, 8'hFF);
      check("t4_count", count, 0);
      step(); step();
      check("t4_no_pulse", wq.size(), 0);

      // 5: six pushes with stall toggling; pointers wrap, count follows model
      mcount = 0;
      for (int i = 0; i < 10; i++) begin
         wr_stall = (i % 2 == 0);
         mpop = (mcount > 0) && !wr_stall;
         if (i < 6) push(3'(i + 1), 8'hA0 + 8'(i));
         else step();
         mcount = mcount + ((i < 6) ? 1 : 0) - (mpop ? 1 : 0);
         check($sformatf("t5_count_%0d", i), count, mcount);
         check($sformatf("t5_wr_en_%0d", i), wr_en, mpop);
      end
      wr_stall = 1'b0;
      repeat (4) step();
      check("t5_writes", wq.size(), 6);
      for (int i = 0; i < 6; i++)
         if (i < wq.size())
            check($sformatf("t5_order_%0d", i), wq[i], {3'(i + 1), 8'hA0 + 8'(i)});
      wq.delete();

`ifdef WB_BYPASS_EN
      // 6: newest pending write to a register wins, including output register
      wr_stall = 1'b1;
      push(3'd2, 8'd10);
      push(3'd2, 8'd20);
      lk_reg1 = 3'd2; lk_reg2 = 3'd0;
      #1;
      check("t6_hit1", lk_hit1, 1);
      check("t6_dat1", lk_dat1, 20);
      check("t6_hit2_r0", lk_hit2, 0);
      check("t6_dat2_r0", lk_dat2, 0);
      lk_reg2 = 3'd5;
      #1;
      check("t6_miss_hit", lk_hit2, 0);
      check("t6_miss_dat", lk_dat2, 0);
      wr_stall = 1'b0;
      step();
      check("t6_first_retire", wr_data, 10);
      check("t6_after1_hit", lk_hit1, 1);
      check("t6_after1_dat", lk_dat1, 20);
      step();
      check("t6_outreg_hit", lk_hit1, 1);
      check("t6_outreg_dat", lk_dat1, 20);
      step();
      check("t6_drained_hit", lk_hit1, 0);
      check("t6_drained_dat", lk_dat1, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
